// File: rtl/xyolo_databus_responder_pkg.sv
// Shared types and helpers for the xyolo databus responder (DDR model behind the read/write stages).
package xyolo_databus_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte-offset bits inside one databus word.
  function automatic int unsigned off_bits(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/xyolo_databus_responder_if.sv
// Versat databus bundle for N_PORTS initiator channels, flattened per channel.
interface xyolo_databus_responder_if #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned ADDR_W  = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [N_PORTS-1:0]        databus_valid;
  logic [N_PORTS-1:0]        databus_ready;
  logic [N_PORTS*ADDR_W-1:0] databus_addr;
  logic [N_PORTS*DATA_W-1:0] databus_wdata;
  logic [N_PORTS*STRB_W-1:0] databus_wstrb;
  logic [N_PORTS*DATA_W-1:0] databus_rdata;

  modport master (
    output databus_valid, databus_addr, databus_wdata, databus_wstrb,
    input  databus_ready, databus_rdata
  );

  modport slave (
    input  databus_valid, databus_addr, databus_wdata, databus_wstrb,
    output databus_ready, databus_rdata
  );
endinterface

// File: rtl/xyolo_databus_responder_be_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module xyolo_databus_responder_be_ram #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (we && be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    rdata <= mem[addr];
  end
endmodule

// File: rtl/xyolo_databus_responder.sv
// Responder end of the versat databus: round-robin arbitration over N_PORTS channels into one
// byte-strobed memory, with separate programmable read and write latencies.
module xyolo_databus_responder
  import xyolo_databus_responder_pkg::*;
#(
  parameter int unsigned N_PORTS    = 2,
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MEM_ADDR_W = 12,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned WR_LAT     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  xyolo_databus_responder_if.slave  bus,
  output logic                      busy
);
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned OFF     = off_bits(DATA_W);
  localparam int unsigned PTR_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     grant_q, grant_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [MEM_ADDR_W-1:0] word_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [STRB_W-1:0]    wstrb_q;
  logic [N_PORTS-1:0]   ready_q, ready_d;
  logic                 busy_q;
  logic [DATA_W-1:0]    rdata_q [N_PORTS];

  logic                 req_any;
  logic [PTR_W-1:0]     req_idx;
  logic                 latch_en;
  logic                 ram_we;
  logic                 rd_load;
  logic [MEM_ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0]    ram_rdata;

  logic [MEM_ADDR_W-1:0] ch_word  [N_PORTS];
  logic [DATA_W-1:0]     ch_wdata [N_PORTS];
  logic [STRB_W-1:0]     ch_wstrb [N_PORTS];

  // Per-channel views of the flattened bus; address bits outside the word index are ignored.
  for (genvar g = 0; g < N_PORTS; g++) begin : g_ch
    assign ch_word[g]  = bus.databus_addr[g*ADDR_W + OFF +: MEM_ADDR_W];
    assign ch_wdata[g] = bus.databus_wdata[g*DATA_W +: DATA_W];
    assign ch_wstrb[g] = bus.databus_wstrb[g*STRB_W +: STRB_W];
    assign bus.databus_rdata[g*DATA_W +: DATA_W] = rdata_q[g];
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.databus_addr;

  // Round-robin: first asserted valid at or after ptr.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    req_any = 1'b0;
    req_idx = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      idx = PTR_W'((32'(ptr_q) + i) % N_PORTS);
      if (!req_any && bus.databus_valid[idx]) begin
        req_any = 1'b1;
        req_idx = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    latch_en = 1'b0;
    ram_we   = 1'b0;
    rd_load  = 1'b0;
    ready_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          grant_d  = req_idx;
          latch_en = 1'b1;
          cnt_d    = (|ch_wstrb[req_idx]) ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          ram_we           = |wstrb_q;
          rd_load          = ~|wstrb_q;
          ready_d[grant_q] = 1'b1;
          state_d          = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        ptr_d   = (32'(grant_q) == N_PORTS - 1) ? '0 : grant_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reads are issued from the bus address while IDLE and from the latched word afterwards,
  // so the registered RAM output already holds the word when the WAIT count expires.
  assign ram_addr = (state_q == ST_IDLE) ? ch_word[req_idx] : word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ready_q <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < N_PORTS; i++) rdata_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      busy_q  <= (state_d != ST_IDLE);
      if (latch_en) begin
        word_q  <= ch_word[req_idx];
        wdata_q <= ch_wdata[req_idx];
        wstrb_q <= ch_wstrb[req_idx];
      end
      if (rd_load) rdata_q[grant_q] <= ram_rdata;
    end
  end

  xyolo_databus_responder_be_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (wstrb_q),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign bus.databus_ready = ready_q;
  assign busy              = busy_q;
endmodule

// File: tb/tb_xyolo_databus_responder.sv
// Scoreboard bench for xyolo_databus_responder: directed transfers, arbitration, strobes, aliasing, reset abort.
module tb_xyolo_databus_responder;
  localparam int unsigned NP  = 2;
  localparam int unsigned DW  = 256;
  localparam int unsigned AW  = 32;
  localparam int unsigned MAW = 12;
  localparam int unsigned RL  = 2;
  localparam int unsigned WL  = 1;
  localparam int unsigned SW  = DW / 8;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; logic [SW-1:0] s; } req_t;
  typedef struct { int ch; bit rd; logic [DW-1:0] data; int cyc; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  logic [NP-1:0]    valid = '0;
  logic [NP*AW-1:0] addr  = '0;
  logic [NP*DW-1:0] wdata = '0;
  logic [NP*SW-1:0] wstrb = '0;

  req_t rq0[$];
  req_t rq1[$];
  exp_t sb[$];
  logic [DW-1:0] last_rd [NP];

  xyolo_databus_responder_if #(.N_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) bus();

  assign bus.databus_valid = valid;
  assign bus.databus_addr  = addr;
  assign bus.databus_wdata = wdata;
  assign bus.databus_wstrb = wstrb;

  xyolo_databus_responder #(
    .N_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .MEM_ADDR_W(MAW), .RD_LAT(RL), .WR_LAT(WL)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_of(input int ch);
    return (ch == 0) ? bus.databus_rdata[DW-1:0] : bus.databus_rdata[2*DW-1:DW];
  endfunction

  task automatic load(input int ch);
    req_t r;
    if (ch == 0) begin
      r = rq0[0];
      addr[AW-1:0] = r.a; wdata[DW-1:0] = r.d; wstrb[SW-1:0] = r.s; valid[0] = 1'b1;
    end else begin
      r = rq1[0];
      addr[2*AW-1:AW] = r.a; wdata[2*DW-1:DW] = r.d; wstrb[2*SW-1:SW] = r.s; valid[1] = 1'b1;
    end
  endtask

  task automatic enq(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_t r;
    r.a = a; r.d = d; r.s = s;
    if (ch == 0) rq0.push_back(r); else rq1.push_back(r);
  endtask

  task automatic expect_resp(input int ch, input bit rd, input logic [DW-1:0] data, input int at);
    exp_t e;
    e.ch = ch; e.rd = rd; e.data = data; e.cyc = at;
    sb.push_back(e);
  endtask

  // Drives queued requests, holding valid until the matching ready; returns in the following IDLE cycle.
  task automatic run();
    int n;
    n = 0;
    if (rq0.size() > 0) load(0);
    if (rq1.size() > 0) load(1);
    while (valid != '0 && n < 200) begin
      @(negedge clk);
      n++;
      if (valid[0] && bus.databus_ready[0]) begin
        rq0.delete(0);
        if (rq0.size() > 0) load(0); else valid[0] = 1'b0;
      end
      if (valid[1] && bus.databus_ready[1]) begin
        rq1.delete(0);
        if (rq1.size() > 0) load(1); else valid[1] = 1'b0;
      end
    end
    chk("run_no_timeout", DW'(valid), '0);
    valid = '0;
    rq0.delete();
    rq1.delete();
    @(negedge clk);
  endtask

  task automatic xfer(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, input logic [DW-1:0] exp);
    int lat;
    lat = (s == '0) ? RL : WL;
    enq(ch, a, d, s);
    expect_resp(ch, (s == '0), exp, cyc + lat + 1);
    run();
  endtask

  // Monitor: pops the scoreboard on every ready pulse.
  initial begin
    exp_t e;
    int   ch;
    last_rd[0] = '0;
    last_rd[1] = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_rd[0] = '0;
        last_rd[1] = '0;
      end else if (bus.databus_ready != '0) begin
        chk("ready_onehot", DW'($countones(bus.databus_ready)), DW'(1));
        ch = bus.databus_ready[1] ? 1 : 0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready at cycle %0d: ready=%b with nothing outstanding", cyc, bus.databus_ready);
        end else begin
          e = sb.pop_front();
          chk("ready_channel", DW'(ch), DW'(e.ch));
          chk("ready_cycle", DW'(cyc), DW'(e.cyc));
          if (e.rd) begin
            chk("rdata", rd_of(e.ch), e.data);
            last_rd[e.ch] = e.data;
          end
          chk("rdata_other_held", rd_of(1 - e.ch), last_rd[1 - e.ch]);
        end
      end
    end
  end

  initial begin
    int t0;
    logic [DW-1:0] ff00;
    ff00 = {{31{8'hFF}}, 8'h00};

    repeat (3) @(negedge clk);
    chk("reset_ready", DW'(bus.databus_ready), '0);
    chk("reset_busy", DW'(busy), '0);
    chk("reset_rdata", bus.databus_rdata[DW-1:0] | bus.databus_rdata[2*DW-1:DW], '0);
    rst = 1'b0;
    @(negedge clk);

    // Full-word write then read (low address bits ignored on the read).
    xfer(0, 32'h40, {32{8'hA5}}, '1, '0);
    xfer(0, 32'h4C, '0, '0, {32{8'hA5}});

    // Byte strobes: only byte 0 cleared.
    xfer(0, 32'h60, {32{8'hFF}}, '1, '0);
    xfer(0, 32'h60, '0, SW'(1), '0);
    xfer(0, 32'h60, '0, '0, ff00);

    // Upper address bits alias onto the same word.
    xfer(1, 32'h40 + (32'd1 << (MAW + 5)), {32{8'h5A}}, '1, '0);
    xfer(0, 32'h40, '0, '0, {32{8'h5A}});

    for (int k = 0; k < 8; k++) xfer(0, 32'((16 + k) * 32), {32{8'(8'h30 + k)}}, '1, '0);
    xfer(1, 32'h60, '0, '0, ff00);

    // Both channels valid together: ch0 first, ch1 RD_LAT+2 cycles later.
    t0 = cyc;
    enq(0, 32'h60, '0, '0);
    enq(1, 32'h40, '0, '0);
    expect_resp(0, 1'b1, ff00, t0 + RL + 1);
    expect_resp(1, 1'b1, {32{8'h5A}}, t0 + 2 * RL + 3);
    run();

    // Continuous valid on both channels: grants alternate.
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      enq(k % 2, 32'((16 + k) * 32), '0, '0);
      expect_resp(k % 2, 1'b1, {32{8'(8'h30 + k)}}, t0 + k * (RL + 2) + RL + 1);
    end
    run();

    // Reset during WAIT of a write: write dropped, everything back to reset state.
    xfer(0, 32'hA0, {32{8'h11}}, '1, '0);
    enq(0, 32'hA0, {32{8'h22}}, '1);
    load(0);
    @(negedge clk);
    chk("busy_in_wait", DW'(busy), DW'(1));
    rst = 1'b1;
    #1;
    chk("busy_after_rst", DW'(busy), '0);
    chk("ready_after_rst", DW'(bus.databus_ready), '0);
    @(negedge clk);
    valid = '0;
    rq0.delete();
    chk("ready_in_rst", DW'(bus.databus_ready), '0);
    chk("rdata0_in_rst", bus.databus_rdata[DW-1:0], '0);
    rst = 1'b0;
    @(negedge clk);
    xfer(0, 32'hA0, '0, '0, {32{8'h11}});

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", DW'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
